// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives a framed byte stream
// (16-bit word count, little-endian payload, XOR checksum), writes the
// assembled 32-bit words to instruction memory from address 0 and keeps
// the CPU in reset until a checksum-verified program is in place.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_RUN  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // Running-checksum step: fold one payload byte into the accumulator.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic                  in_ready_r;
    logic                  cpu_reset_r;
    logic                  done_r;
    logic                  error_r;
    logic                  ready_nx_s;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic [7:0]            len_lo_r;
    logic [15:0]           last_idx_r;
    logic [15:0]           word_idx_r;
    logic [1:0]            byte_idx_r;
    logic [23:0]           stage_r;
    logic [7:0]            csum_r;

    logic                  hs_s;
    logic [15:0]           len_s;
    logic                  len_ok_s;
    logic                  last_byte_s;

    assign hs_s        = in_valid && in_ready_r;
    assign len_s       = {in_data, len_lo_r};
    // Zero-length and over-capacity programs are rejected; exactly 2^ADDR_WIDTH fits.
    assign len_ok_s    = (len_s != 16'd0) && ({1'b0, len_s} <= (17'd1 << ADDR_WIDTH));
    assign last_byte_s = (byte_idx_r == 2'd3) && (word_idx_r == last_idx_r);

    assign in_ready  = in_ready_r;
    assign cpu_reset = cpu_reset_r;
    assign done      = done_r;
    assign error     = error_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    // Next-state decode; status outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nx_s = S_LEN0;
                else       state_nx_s = S_IDLE;
            end
            S_LEN0: begin
                if (hs_s) state_nx_s = S_LEN1;
                else      state_nx_s = S_LEN0;
            end
            S_LEN1: begin
                if (hs_s) state_nx_s = len_ok_s ? S_DATA : S_ERR;
                else      state_nx_s = S_LEN1;
            end
            S_DATA: begin
                if (hs_s && last_byte_s) state_nx_s = S_CSUM;
                else                     state_nx_s = S_DATA;
            end
            S_CSUM: begin
                if (hs_s) state_nx_s = (in_data == csum_r) ? S_RUN : S_ERR;
                else      state_nx_s = S_CSUM;
            end
            S_RUN, S_ERR: begin
                if (start) state_nx_s = S_LEN0;
                else       state_nx_s = state_r;
            end
            default: state_nx_s = S_IDLE;
        endcase
        ready_nx_s = (state_nx_s == S_LEN0) || (state_nx_s == S_LEN1) ||
                     (state_nx_s == S_DATA) || (state_nx_s == S_CSUM);
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b0;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= ready_nx_s;
            cpu_reset_r <= (state_nx_s != S_RUN);
            done_r      <= (state_nx_s == S_RUN);
            error_r     <= (state_nx_s == S_ERR);
        end
    end

    // Datapath: length capture, byte-lane staging, checksum and the one-cycle write strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            len_lo_r    <= 8'd0;
            last_idx_r  <= 16'd0;
            word_idx_r  <= 16'd0;
            byte_idx_r  <= 2'd0;
            stage_r     <= 24'd0;
            csum_r      <= 8'd0;
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                S_LEN0: begin
                    if (hs_s) len_lo_r <= in_data;
                end
                S_LEN1: begin
                    if (hs_s) begin
                        last_idx_r <= len_s - 16'd1;
                        word_idx_r <= 16'd0;
                        byte_idx_r <= 2'd0;
                        csum_r     <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (hs_s) begin
                        csum_r     <= csum_step(csum_r, in_data);
                        byte_idx_r <= byte_idx_r + 2'd1;
                        case (byte_idx_r)
                            2'd0: stage_r[7:0]   <= in_data;
                            2'd1: stage_r[15:8]  <= in_data;
                            2'd2: stage_r[23:16] <= in_data;
                            2'd3: begin
                                mem_we_r    <= 1'b1;
                                mem_addr_r  <= word_idx_r[ADDR_WIDTH-1:0];
                                mem_wdata_r <= {in_data, stage_r};
                                word_idx_r  <= word_idx_r + 16'd1;
                            end
                            default: stage_r <= stage_r;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: nominal load, bad checksum, length
// bounds, stream gaps with an ignored start, reset mid-load and reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frm[$];
    logic [7:0]  wr_addr[0:299];
    logic [31:0] wr_data[0:299];
    int          wr_cnt = 0;
    logic [7:0]  cs;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 300) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int start_at);
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    in_data  = 8'hEE;
                    tick();
                end
            end
            if (i == start_at) start = 1'b1;
            send(frm[i]);
            start = 1'b0;
        end
    endtask

    task automatic nominal_frame(input logic [7:0] csum);
        frm = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00,
                8'hb3, 8'h81, 8'h20, 8'h00, csum};
    endtask

    task automatic check_nominal_writes(input string tag);
        chk({tag, "_wrcnt"}, wr_cnt, 32'd3);
        chk({tag, "_a0"}, {24'd0, wr_addr[0]}, 32'd0);
        chk({tag, "_d0"}, wr_data[0], 32'h00100093);
        chk({tag, "_a1"}, {24'd0, wr_addr[1]}, 32'd1);
        chk({tag, "_d1"}, wr_data[1], 32'h00200113);
        chk({tag, "_a2"}, {24'd0, wr_addr[2]}, 32'd2);
        chk({tag, "_d2"}, wr_data[2], 32'h002081b3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // Nominal load with write-timing checks on word 0.
        wr_cnt = 0;
        do_start();
        chk("nom_ready", {31'd0, in_ready}, 32'd1);
        send(8'h03); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        chk("nom_we_w0", {31'd0, mem_we}, 32'd1);
        chk("nom_addr_w0", {24'd0, mem_addr}, 32'd0);
        chk("nom_wdata_w0", mem_wdata, 32'h00100093);
        send(8'h13);
        chk("nom_we_drop", {31'd0, mem_we}, 32'd0);
        send(8'h01); send(8'h20); send(8'h00);
        send(8'hb3); send(8'h81); send(8'h20); send(8'h00);
        chk("nom_pre_done", {31'd0, done}, 32'd0);
        send(8'hA3);
        chk("nom_done", {31'd0, done}, 32'd1);
        chk("nom_cpurst", {31'd0, cpu_reset}, 32'd0);
        chk("nom_ready_run", {31'd0, in_ready}, 32'd0);
        check_nominal_writes("nom");

        // Bad checksum, started from RUN.
        wr_cnt = 0;
        nominal_frame(8'hA2);
        do_start();
        chk("bad_cpurst_start", {31'd0, cpu_reset}, 32'd1);
        chk("bad_done_clr", {31'd0, done}, 32'd0);
        send_frame(1'b0, -1);
        chk("bad_error", {31'd0, error}, 32'd1);
        chk("bad_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("bad_done", {31'd0, done}, 32'd0);
        chk("bad_wrcnt", wr_cnt, 32'd3);

        // N = 0 rejected with no writes.
        wr_cnt = 0;
        do_start();
        chk("n0_err_clr", {31'd0, error}, 32'd0);
        send(8'h00);
        send(8'h00);
        chk("n0_error", {31'd0, error}, 32'd1);
        tick();
        chk("n0_wrcnt", wr_cnt, 32'd0);

        // N = 257 rejected.
        do_start();
        send(8'h01);
        send(8'h01);
        chk("n257_error", {31'd0, error}, 32'd1);

        // N = 256 fills the whole memory.
        wr_cnt = 0;
        frm = '{8'h00, 8'h01};
        cs  = 8'h00;
        for (int k = 0; k < 256; k++) begin
            frm.push_back(k[7:0]); frm.push_back(8'hA5);
            frm.push_back(8'h00);  frm.push_back(8'h5A);
            cs = cs ^ k[7:0] ^ 8'hA5 ^ 8'h00 ^ 8'h5A;
        end
        frm.push_back(cs);
        do_start();
        send_frame(1'b0, -1);
        chk("n256_done", {31'd0, done}, 32'd1);
        chk("n256_error", {31'd0, error}, 32'd0);
        chk("n256_wrcnt", wr_cnt, 32'd256);
        chk("n256_addr_last", {24'd0, wr_addr[255]}, 32'h000000FF);
        chk("n256_data_last", wr_data[255], 32'h5A00A5FF);
        chk("n256_data_80", wr_data[128], 32'h5A00A580);

        // Random gaps plus a start pulse mid-DATA.
        wr_cnt = 0;
        nominal_frame(8'hA3);
        do_start();
        send_frame(1'b1, 7);
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_cpurst", {31'd0, cpu_reset}, 32'd0);
        check_nominal_writes("gap");

        // Reset after 6 payload bytes, then a full load.
        do_start();
        send(8'h03); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'h13); send(8'h01);
        reset = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b1;
        tick();
        wr_cnt = 0;
        do_start();
        send_frame(1'b0, -1);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        check_nominal_writes("postrst");

        // Reload a one-word program from RUN.
        wr_cnt = 0;
        frm = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        do_start();
        chk("rel_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("rel_done_clr", {31'd0, done}, 32'd0);
        send_frame(1'b0, -1);
        chk("rel_done", {31'd0, done}, 32'd1);
        chk("rel_wrcnt", wr_cnt, 32'd1);
        chk("rel_addr", {24'd0, wr_addr[0]}, 32'd0);
        chk("rel_data", wr_data[0], 32'h00000013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
